// File: rtl/fifo_decimation_drain_master.sv
// Avalon-MM read master draining a decimation FIFO: keeps 1 of every DECIM words
// and forwards them on a valid/ready stream through a 2-entry skid buffer.
module fifo_decimation_drain_master #(
  parameter int DATA_W = 32,
  parameter int DECIM  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              rdclock,
  input  logic              rdreset,
  input  logic              enable,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  kept_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {REQ_IDLE, REQ_HOLD} req_state_e;

  req_state_e        state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [CNT_W-1:0]  kept_q, kept_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic       push, pop, keep, credit_ok, rd_req;
  logic [2:0] used;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign kept_cnt  = kept_q;
  assign drop_cnt  = drop_q;

  assign pop  = out_valid && out_ready;
  assign keep = (phase_q == '0);
  assign push = inflight_q && keep;

  // A slot being popped this cycle counts as free, so a drained stream sustains one read per cycle.
  assign used      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign credit_ok = (used < 3'd2);

  always_comb begin
    state_d = REQ_IDLE;
    rd_req  = 1'b0;
    if (!rdreset) begin
      rd_req = (state_q == REQ_HOLD) || (enable && credit_ok);
      if (rd_req && avm_waitrequest) state_d = REQ_HOLD;
    end
    avm_read = rd_req;
  end

  always_comb begin
    inflight_d = avm_read && !avm_waitrequest;
    phase_d    = phase_q;
    kept_d     = kept_q;
    drop_d     = drop_q;
    if (inflight_q) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
      if (keep) kept_d = kept_q + CNT_W'(1);
      else      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = avm_readdata;
        else               buf1_d = avm_readdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = avm_readdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = avm_readdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rdclock) begin
    if (rdreset) begin
      state_q    <= REQ_IDLE;
      inflight_q <= 1'b0;
      phase_q    <= '0;
      occ_q      <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      kept_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      phase_q    <= phase_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      kept_q     <= kept_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fifo_decimation_drain_master.sv
// Bench for fifo_decimation_drain_master: three instances (DECIM 4/1/2) checked
// against a word-index decimation model with a queue-based FIFO slave.
module tb_fifo_decimation_drain_master;

  localparam int NI = 3;

  function automatic int dec_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    return (i == 1) ? 4 : 16;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        enable    [NI];
  logic        avm_read  [NI];
  logic        waitreq   [NI];
  logic [31:0] rdata     [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [31:0] out_data  [NI];
  logic [15:0] kept      [NI];
  logic [15:0] drop      [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = cw_of(g);
    logic [CW-1:0] kc, dc;
    fifo_decimation_drain_master #(.DATA_W(32), .DECIM(dec_of(g)), .CNT_W(CW)) u_dut (
      .rdclock        (clk),
      .rdreset        (rst),
      .enable         (enable[g]),
      .avm_read       (avm_read[g]),
      .avm_waitrequest(waitreq[g]),
      .avm_readdata   (rdata[g]),
      .out_valid      (out_valid[g]),
      .out_ready      (out_ready[g]),
      .out_data       (out_data[g]),
      .kept_cnt       (kc),
      .drop_cnt       (dc)
    );
    assign kept[g] = 16'(kc);
    assign drop[g] = 16'(dc);
  end

  int nchk = 0;
  int nerr = 0;
  int cur, cur_dec, cur_mask;
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int n_idx, exp_kept, exp_drop, n_acc, streak, max_streak, rdy_mode;
  bit force_wait, seen_read, seen_acc, seen_valid, prev_stall;
  logic [31:0] prev_data;

  task automatic clear_model();
    exp_q.delete();
    n_idx = 0; exp_kept = 0; exp_drop = 0; n_acc = 0;
    streak = 0; max_streak = 0; prev_stall = 1'b0;
  endtask

  task automatic select(input int i);
    cur = i;
    cur_dec = dec_of(i);
    cur_mask = (1 << cw_of(i)) - 1;
    src_q.delete();
    force_wait = 1'b0;
    clear_model();
  endtask

  task automatic load(input int n, input bit seq);
    for (int i = 0; i < n; i++) src_q.push_back(seq ? 32'(i) : 32'($urandom));
    waitreq[cur] = force_wait || (src_q.size() == 0);
  endtask

  // One clock: observe outputs at negedge, then act as FIFO slave and sink after posedge.
  task automatic step();
    logic [31:0] w;
    bit pop;
    @(negedge clk);
    seen_read  = avm_read[cur];
    seen_valid = out_valid[cur];
    seen_acc   = avm_read[cur] && !waitreq[cur];
    pop        = out_valid[cur] && out_ready[cur];
    if (pop) begin
      nchk++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL out_extra: got %h, required no word", out_data[cur]);
      end else begin
        w = exp_q.pop_front();
        if (out_data[cur] !== w) begin
          nerr++;
          $display("FAIL out_order: got %h, required %h", out_data[cur], w);
        end
      end
    end
    if (out_valid[cur] && !out_ready[cur]) begin
      if (prev_stall) begin
        nchk++;
        if (out_data[cur] !== prev_data) begin
          nerr++;
          $display("FAIL out_stable: got %h, required %h", out_data[cur], prev_data);
        end
      end
      prev_stall = 1'b1;
      prev_data  = out_data[cur];
    end else begin
      prev_stall = 1'b0;
    end
    if (seen_acc) begin
      streak++;
      if (streak > max_streak) max_streak = streak;
    end else begin
      streak = 0;
    end
    @(posedge clk);
    #1;
    if (seen_acc) begin
      n_acc++;
      w = src_q.pop_front();
      rdata[cur] = w;
      if (n_idx % cur_dec == 0) begin
        exp_q.push_back(w);
        exp_kept++;
      end else begin
        exp_drop++;
      end
      n_idx++;
    end else begin
      rdata[cur] = $urandom;
    end
    waitreq[cur] = force_wait || (src_q.size() == 0);
    case (rdy_mode)
      0:       out_ready[cur] = 1'b0;
      1:       out_ready[cur] = 1'b1;
      default: out_ready[cur] = ~out_ready[cur];
    endcase
  endtask

  task automatic check_counts(input string tag);
    nchk++;
    if (kept[cur] !== 16'(exp_kept & cur_mask)) begin
      nerr++;
      $display("FAIL %s_kept: got %0d, required %0d", tag, kept[cur], exp_kept & cur_mask);
    end
    nchk++;
    if (drop[cur] !== 16'(exp_drop & cur_mask)) begin
      nerr++;
      $display("FAIL %s_drop: got %0d, required %0d", tag, drop[cur], exp_drop & cur_mask);
    end
    nchk++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s_drain: got %0d words left, required 0", tag, exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      enable[i] = 1'b0; waitreq[i] = 1'b1; out_ready[i] = 1'b0; rdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      nchk++;
      if (avm_read[i] !== 1'b0) begin nerr++; $display("FAIL rst_read[%0d]: got %b, required 0", i, avm_read[i]); end
      nchk++;
      if (out_valid[i] !== 1'b0) begin nerr++; $display("FAIL rst_valid[%0d]: got %b, required 0", i, out_valid[i]); end
      nchk++;
      if (out_data[i] !== 32'h0) begin nerr++; $display("FAIL rst_data[%0d]: got %h, required 0", i, out_data[i]); end
      nchk++;
      if (kept[i] !== 16'h0) begin nerr++; $display("FAIL rst_kept[%0d]: got %0d, required 0", i, kept[i]); end
      nchk++;
      if (drop[i] !== 16'h0) begin nerr++; $display("FAIL rst_drop[%0d]: got %0d, required 0", i, drop[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decim4();
    select(0);
    rdy_mode = 1;
    out_ready[0] = 1'b1;
    load(16, 1'b1);
    enable[0] = 1'b1;
    repeat (30) step();
    nchk++;
    if (max_streak != 16) begin nerr++; $display("FAIL t1_streak: got %0d, required 16", max_streak); end
    nchk++;
    if (n_acc != 16) begin nerr++; $display("FAIL t1_accepts: got %0d, required 16", n_acc); end
    check_counts("t1");
  endtask

  task automatic test_hold();
    int acc0, tries;
    force_wait = 1'b1;
    load(4, 1'b0);
    acc0 = n_acc;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!seen_read && tries < 10);
    nchk++;
    if (!seen_read) begin nerr++; $display("FAIL t2_raise: got avm_read=0, required 1 within 10 cycles"); end
    enable[0] = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      if (i == 5) force_wait = 1'b0;
      step();
      nchk++;
      if (!seen_read || seen_acc) begin
        nerr++;
        $display("FAIL t2_hold: cycle %0d got read=%b acc=%b, required read=1 acc=0", i, seen_read, seen_acc);
      end
    end
    step();
    nchk++;
    if (!seen_acc) begin nerr++; $display("FAIL t2_accept: got acc=0, required 1"); end
    for (int i = 0; i < 4; i++) begin
      step();
      nchk++;
      if (seen_read) begin nerr++; $display("FAIL t2_release: got avm_read=1, required 0"); end
    end
    nchk++;
    if (n_acc - acc0 != 1) begin nerr++; $display("FAIL t2_count: got %0d accepts, required 1", n_acc - acc0); end
    check_counts("t2");
    src_q.delete();
    waitreq[0] = 1'b1;
  endtask

  task automatic test_backpressure();
    select(1);
    rdy_mode = 0;
    out_ready[1] = 1'b0;
    load(10, 1'b0);
    enable[1] = 1'b1;
    repeat (12) step();
    nchk++;
    if (n_acc != 2) begin nerr++; $display("FAIL t3_accepts: got %0d, required 2", n_acc); end
    nchk++;
    if (seen_read || !seen_valid) begin
      nerr++;
      $display("FAIL t3_full: got read=%b valid=%b, required read=0 valid=1", seen_read, seen_valid);
    end
    rdy_mode = 1;
    repeat (20) step();
    check_counts("t3");
    load(5, 1'b0);
    repeat (12) step();
    check_counts("wrap15");
    load(2, 1'b0);
    repeat (10) step();
    check_counts("wrap1");
    nchk++;
    if (kept[1] !== 16'd1) begin nerr++; $display("FAIL wrap_value: got %0d, required 1", kept[1]); end
  endtask

  task automatic test_toggle();
    select(2);
    rdy_mode = 2;
    load(20, 1'b1);
    enable[2] = 1'b1;
    repeat (70) step();
    check_counts("t4");
  endtask

  task automatic test_reset_mid();
    int tries;
    select(0);
    enable[0] = 1'b0;
    rdy_mode = 0;
    pulse_reset();
    load(12, 1'b0);
    enable[0] = 1'b1;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!seen_acc && tries < 5);
    nchk++;
    if (!seen_acc) begin nerr++; $display("FAIL t5_start: got no accept, required one within 5 cycles"); end
    step();
    rst = 1'b1;
    enable[0] = 1'b0;
    step();
    nchk++;
    if (seen_read) begin nerr++; $display("FAIL t5_rst_read: got avm_read=1, required 0"); end
    rst = 1'b0;
    clear_model();
    step();
    nchk++;
    if (seen_read || seen_valid) begin
      nerr++;
      $display("FAIL t5_after: got read=%b valid=%b, required 0 0", seen_read, seen_valid);
    end
    check_counts("t5_clear");
    rdy_mode = 1;
    enable[0] = 1'b1;
    repeat (30) step();
    check_counts("t5_resume");
  endtask

  initial begin
    test_reset();
    test_decim4();
    test_hold();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
